// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_disp_pkg;

  localparam int DISP_DIGITS  = 8;
  localparam int DISP_VALUE_W = 32;

  // IDLE: no dwell active, the last granted value stays on screen.
  // HOLD: dwell timer running, no grants are issued.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic [DISP_DIGITS-1:0] digit_mask_t;

  // Next round-robin pointer after a grant to idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set bit of req, searching
// upward from ptr and wrapping at N. The pointer register is owned by
// the caller; this block only decodes.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] probe;

  // Walk the N candidate positions starting at ptr; the first requesting one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    probe = '0;
    for (int k = 0; k < N; k++) begin
      probe = IW'((int'(ptr) + k) % N);
      if (!any && req[probe]) begin
        any          = 1'b1;
        grant[probe] = 1'b1;
        idx          = probe;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares one 8-digit seven-segment display between NUM_REQ requesters.
// Round-robin grants, each granted value held for at least HOLD_CYCLES.
//
// Handshake: a transfer happens in any cycle where req_valid[i] and
// req_ready[i] are both 1. req_ready is combinational, one-hot, and only
// nonzero while IDLE; req_value/req_mask are sampled in that cycle only.
// Requesters must not make req_valid depend on req_ready.
//
// Timing of a grant in cycle T: the new value is on the outputs from
// T+1 through T+HOLD_CYCLES, disp_busy is 1 for T+1..T+HOLD_CYCLES-1,
// and the next grant can be issued in cycle T+HOLD_CYCLES, so the
// display never shows a value for fewer than HOLD_CYCLES cycles.
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DISP_VALUE_W-1:0] req_value,
  input  logic [NUM_REQ*DISP_DIGITS-1:0]  req_mask,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           pin_en,
  input  logic [$clog2(NUM_REQ)-1:0]     pin_sel,
  output logic [DISP_VALUE_W-1:0]        disp_value,
  output digit_mask_t                    disp_aen,
  output logic [$clog2(NUM_REQ)-1:0]     disp_owner,
  output logic                           disp_busy,
  output state_t                         dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  ptr_q;
  logic              run_q;
  logic              take;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  // Eligibility: all valids, or only the pinned requester when pinning is on.
  // An out-of-range pin selects nobody.
  always_comb begin
    eligible = req_valid;
    if (pin_en) begin
      eligible = '0;
      if (int'(pin_sel) < NUM_REQ) begin
        eligible[pin_sel] = req_valid[pin_sel];
      end
    end
  end

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Next-state, dwell counter and ready decode. The counter is loaded with
  // HOLD_CYCLES-1 on a grant and the state returns to IDLE on the edge where
  // it reaches zero, which opens the grant window in cycle T+HOLD_CYCLES.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    take      = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_q && arb_any) begin
          req_ready = arb_grant;
          take      = 1'b1;
          if (HOLD_CYCLES > 1) begin
            state_d = HOLD;
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          end
        end
      end
      HOLD: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, dwell counter and the post-reset run enable. run_q keeps
  // req_ready at zero while reset is asserted and for the first cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  // Display registers and round-robin pointer, loaded only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_value <= '0;
      disp_aen   <= '0;
      disp_owner <= '0;
      ptr_q      <= '0;
    end else if (take) begin
      disp_value <= req_value[DISP_VALUE_W*arb_idx +: DISP_VALUE_W];
      disp_aen   <= req_mask[DISP_DIGITS*arb_idx +: DISP_DIGITS];
      disp_owner <= arb_idx;
      ptr_q      <= IDX_W'(rr_next(int'(arb_idx), NUM_REQ));
    end
  end

  assign disp_busy = (state_q == HOLD);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter: main instance with NUM_REQ=4,
// HOLD_CYCLES=4 and a second instance with HOLD_CYCLES=1.
module tb_seg_display_arbiter;
  import seg_disp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- DUT 0 (HOLD_CYCLES=4) ----------------
  logic [3:0]   req_valid;
  logic [127:0] req_value;
  logic [31:0]  req_mask;
  logic [3:0]   req_ready;
  logic         pin_en;
  logic [1:0]   pin_sel;
  logic [31:0]  disp_value;
  logic [7:0]   disp_aen;
  logic [1:0]   disp_owner;
  logic         disp_busy;
  state_t       dbg_state;

  seg_display_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_value  (req_value),
    .req_mask   (req_mask),
    .req_ready  (req_ready),
    .pin_en     (pin_en),
    .pin_sel    (pin_sel),
    .disp_value (disp_value),
    .disp_aen   (disp_aen),
    .disp_owner (disp_owner),
    .disp_busy  (disp_busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- DUT 1 (HOLD_CYCLES=1) ----------------
  logic [3:0]   req_valid1;
  logic [127:0] req_value1;
  logic [31:0]  req_mask1;
  logic [3:0]   req_ready1;
  logic [31:0]  disp_value1;
  logic [7:0]   disp_aen1;
  logic [1:0]   disp_owner1;
  logic         disp_busy1;
  state_t       dbg_state1;

  seg_display_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid1),
    .req_value  (req_value1),
    .req_mask   (req_mask1),
    .req_ready  (req_ready1),
    .pin_en     (1'b0),
    .pin_sel    (2'd0),
    .disp_value (disp_value1),
    .disp_aen   (disp_aen1),
    .disp_owner (disp_owner1),
    .disp_busy  (disp_busy1),
    .dbg_state  (dbg_state1)
  );

  // ---------------- scoreboard ----------------
  int          n_checks;
  int          n_errors;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] val, input logic [7:0] msk);
    req_value[32*i +: 32] = val;
    req_mask[8*i +: 8]    = msk;
  endtask

  // Wait (bounded) for a grant to exp_idx, then check the loaded display.
  task automatic expect_grant(input string tag, input int exp_idx,
                              input logic [31:0] exp_val, output int gcyc);
    bit done;
    done = 1'b0;
    gcyc = -1;
    for (int i = 0; i < 12 && !done; i++) begin
      #1;
      if (req_ready != 4'b0000) begin
        check({tag, "_ready"}, 32'(req_ready), 32'(1 << exp_idx));
        gcyc = cyc_cnt;
        tick();
        check({tag, "_owner"}, 32'(disp_owner), 32'(exp_idx));
        check({tag, "_value"}, disp_value, exp_val);
        check({tag, "_busy"}, 32'(disp_busy), 32'd1);
        done = 1'b1;
      end else begin
        tick();
      end
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      if (!disp_busy) idle = 1'b1;
      else tick();
    end
    if (!idle) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int g_prev, g_now, e, grants;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    cyc_cnt    = 0;
    rst_n      = 1'b1;
    req_valid  = '0;
    req_value  = '0;
    req_mask   = '0;
    pin_en     = 1'b0;
    pin_sel    = '0;
    req_valid1 = '0;
    req_value1 = '0;
    req_mask1  = '0;
    #1 rst_n = 1'b0;
    #2;

    // 1. reset values, then 20 idle cycles with no valids
    check("rst_value", disp_value, 32'h0);
    check("rst_aen",   32'(disp_aen), 32'h0);
    check("rst_owner", 32'(disp_owner), 32'h0);
    check("rst_busy",  32'(disp_busy), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t1_aen",   32'(disp_aen), 32'h0);
      check("t1_value", disp_value, 32'h0);
      check("t1_ready", 32'(req_ready), 32'h0);
    end

    // 2. single grant to requester 2, dwell timing, late-change ignored
    req_valid = 4'b0100;
    set_req(2, 32'hDEADBEEF, 8'hFF);
    #1;
    check("t2_ready_T", 32'(req_ready), 32'h4);
    tick();                                   // T+1
    req_valid = 4'b0000;
    set_req(2, 32'hCAFEF00D, 8'h00);
    #1;
    check("t2_value_T1", disp_value, 32'hDEADBEEF);
    check("t2_aen_T1",   32'(disp_aen), 32'hFF);
    check("t2_owner_T1", 32'(disp_owner), 32'd2);
    check("t2_busy_T1",  32'(disp_busy), 32'd1);
    check("t2_state_T1", 32'(dbg_state), 32'(HOLD));
    tick();                                   // T+2
    check("t2_busy_T2",  32'(disp_busy), 32'd1);
    check("t2_value_T2", disp_value, 32'hDEADBEEF);
    tick();                                   // T+3
    req_valid = 4'b1000;
    set_req(3, 32'h00001234, 8'h0F);
    #1;
    check("t2_busy_T3",  32'(disp_busy), 32'd1);
    check("t2_ready_T3", 32'(req_ready), 32'h0);
    check("t2_value_T3", disp_value, 32'hDEADBEEF);
    tick();                                   // T+4: earliest next grant
    check("t2_busy_T4",  32'(disp_busy), 32'd0);
    check("t2_ready_T4", 32'(req_ready), 32'h8);
    check("t2_value_T4", disp_value, 32'hDEADBEEF);
    tick();                                   // T+5
    req_valid = 4'b0000;
    check("t2_value_T5", disp_value, 32'h00001234);
    check("t2_aen_T5",   32'(disp_aen), 32'h0F);
    check("t2_owner_T5", 32'(disp_owner), 32'd3);
    wait_idle("t2");

    // 3. all valid: owners 0,1,2,3,0 spaced four cycles apart
    for (int i = 0; i < 4; i++) set_req(i, 32'hA0000000 + 32'(i), 8'h01 << i);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd0);
    req_valid = 4'b1111;
    g_prev = -1;
    while (exp_q.size() > 0) begin
      e = int'(exp_q.pop_front());
      expect_grant("t3", e, 32'hA0000000 + 32'(e), g_now);
      if (g_prev >= 0) check("t3_gap", 32'(g_now - g_prev), 32'd4);
      g_prev = g_now;
    end
    req_valid = 4'b0000;
    wait_idle("t3");

    // same requester re-wins only when alone; then wrap from pointer 2 to 0
    req_valid = 4'b0010;
    set_req(1, 32'h0000B001, 8'h3C);
    expect_grant("rewin_a", 1, 32'h0000B001, g_prev);
    expect_grant("rewin_b", 1, 32'h0000B001, g_now);
    check("rewin_gap", 32'(g_now - g_prev), 32'd4);
    req_valid = 4'b0011;
    set_req(0, 32'h0000C000, 8'h00);          // blank mask still granted
    expect_grant("wrap0", 0, 32'h0000C000, g_now);
    check("wrap0_aen", 32'(disp_aen), 32'h00);
    req_valid = 4'b0000;
    wait_idle("wrap0");

    // 4. pinned to requester 3 with every requester valid
    pin_en    = 1'b1;
    pin_sel   = 2'd3;
    req_valid = 4'b1111;
    grants    = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("t4_ready_other", 32'(req_ready & 4'b0111), 32'h0);
      if (req_ready[3]) grants++;
      tick();
    end
    check("t4_grants", 32'(grants), 32'd4);
    check("t4_owner",  32'(disp_owner), 32'd3);
    pin_en    = 1'b0;
    req_valid = 4'b0000;
    wait_idle("t4");

    // 5. reset asserted mid-dwell with counter at 2
    req_valid = 4'b0010;
    set_req(1, 32'h55555555, 8'hAA);
    expect_grant("t5", 1, 32'h55555555, g_now);   // now in T+1
    tick();                                       // T+2
    rst_n = 1'b0;
    #1;
    check("t5_aen",   32'(disp_aen), 32'h00);
    check("t5_busy",  32'(disp_busy), 32'd0);
    check("t5_ready", 32'(req_ready), 32'h0);
    check("t5_value", disp_value, 32'h0);
    check("t5_owner", 32'(disp_owner), 32'd0);
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    tick();

    // 6. HOLD_CYCLES=1 instance: grants alternate 0,1 every cycle, never busy
    req_value1[31:0]  = 32'h11110000;
    req_value1[63:32] = 32'h11110001;
    req_mask1[7:0]    = 8'h0F;
    req_mask1[15:8]   = 8'hF0;
    req_valid1        = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      e = k % 2;
      #1;
      check("t6_ready", 32'(req_ready1), 32'(1 << e));
      check("t6_busy",  32'(disp_busy1), 32'd0);
      tick();
      check("t6_owner", 32'(disp_owner1), 32'(e));
      check("t6_value", disp_value1, 32'h11110000 + 32'(e));
    end
    req_valid1 = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
